// File: rtl/sample_fifo_sync.sv
// Ready/valid sample FIFO built on a 1R1W RAM with a 1-cycle registered read.
// Optional macro SAMPLE_FIFO_COUNT_EN drives count_o with live occupancy; otherwise count_o is 0.
module sample_fifo_sync #(
   parameter int width_p = 8,
   parameter int depth_p = 512
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       valid_i,
   input  logic [width_p-1:0]         data_i,
   output logic                       ready_o,
   output logic                       valid_o,
   output logic [width_p-1:0]         data_o,
   input  logic                       ready_i,
   output logic [$clog2(depth_p):0]   count_o
);
   localparam int aw_lp = $clog2(depth_p);
   localparam int cw_lp = aw_lp + 1;

   logic [width_p-1:0] mem [depth_p];
   logic [width_p-1:0] data_reg;
   logic [aw_lp-1:0]   wr_ptr_reg;
   logic [aw_lp-1:0]   rd_ptr_reg;
   logic [cw_lp-1:0]   count_reg;
   logic [cw_lp-1:0]   count_next;
   logic [cw_lp-1:0]   avail_reg;
   logic [cw_lp-1:0]   avail_next;
   logic               ready_reg;
   logic               valid_reg;
   logic               push;
   logic               pop;
   logic               rd_en;

   assign push = valid_i & ready_reg;
   assign pop  = valid_reg & ready_i;
   // avail_reg only counts entries written on earlier edges, so a read never
   // targets the address being written on the same edge.
   assign rd_en = (avail_reg != '0) & (~valid_reg | ready_i);

   always_comb begin
      count_next = count_reg;
      case ({push, pop})
         2'b10:   count_next = count_reg + cw_lp'(1);
         2'b01:   count_next = count_reg - cw_lp'(1);
         default: count_next = count_reg;
      endcase
      avail_next = avail_reg + cw_lp'(push) - cw_lp'(rd_en);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         avail_reg  <= '0;
         ready_reg  <= 1'b0;
         valid_reg  <= 1'b0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + aw_lp'(1);
         if (rd_en)
            rd_ptr_reg <= rd_ptr_reg + aw_lp'(1);
         count_reg <= count_next;
         avail_reg <= avail_next;
         ready_reg <= (count_next < cw_lp'(depth_p));
         if (rd_en)
            valid_reg <= 1'b1;
         else if (pop)
            valid_reg <= 1'b0;
      end
   end

   // Storage and its registered read port; the read register is the output stage.
   always_ff @(posedge clk_i) begin
      if (push)
         mem[wr_ptr_reg] <= data_i;
      if (rd_en)
         data_reg <= mem[rd_ptr_reg];
   end

   assign ready_o = ready_reg;
   assign valid_o = valid_reg;
   assign data_o  = data_reg;

`ifdef SAMPLE_FIFO_COUNT_EN
   assign count_o = count_reg;
`else
   assign count_o = '0;
`endif

endmodule
